varint_encoder: RTL and testbench

Serialises one 64-bit unsigned field value into the protobuf base-128 varint byte stream, one byte per cycle, least-significant group first. It sits directly downstream of the zigzag stage and consumes its `out_val`, which is already a non-negative integer for sint32/sint64 fields. It also accepts raw uint/int values that bypass zigzag. Bytes leave over a valid/ready stream toward the field packer.

---
 rtl/varint_if.sv | 27 ++
 rtl/varint_encoder.sv | 116 +++++++++++
 tb/tb_varint_encoder.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/varint_if.sv
// varint_if: stream bundle around the varint encoder.
//   in_valid/in_ready/in_val   : value stream into the encoder
//   out_valid/out_ready        : byte stream toward the field packer
//   out_byte/out_last/out_len  : encoded byte, final-byte flag, total varint length
// master = value producer / byte consumer side, slave = encoder side.
interface varint_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_val;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic [3:0]        out_len;

  modport master (
    output in_valid, in_val, out_ready,
    input  in_ready, out_valid, out_byte, out_last, out_len
  );

  modport slave (
    input  in_valid, in_val, out_ready,
    output in_ready, out_valid, out_byte, out_last, out_len
  );
endinterface

// File: rtl/varint_encoder.sv
// varint_encoder: serialises a 64-bit unsigned value into a protobuf base-128
// varint, one byte per cycle, least-significant 7-bit group first.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : varint_if.slave (value in, encoded bytes out)
//
// state | meaning
// IDLE  | no varint in flight, ready for a value
// EMIT  | out_byte holds a byte of the current varint
module varint_encoder #(
  parameter int DATA_W    = 64,
  parameter int MAX_BYTES = (DATA_W + 6) / 7
) (
  input  logic     clk,
  input  logic     rst_n,
  varint_if.slave  bus
);

  localparam int SHIFT_W = DATA_W - 7;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_q, state_d;
  logic               valid_q, valid_d;
  logic               last_q, last_d;
  logic [7:0]         byte_q, byte_d;
  logic [3:0]         len_q, len_d;
  logic [3:0]         rem_q, rem_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;

  logic [3:0] in_len;
  logic       take;
  logic       accept;

  // Length = index of the highest non-empty 7-bit group + 1 (0 encodes as 1 byte).
  always_comb begin
    in_len = 4'd1;
    for (int k = 1; k < MAX_BYTES; k++) begin
      if (|(bus.in_val >> (7 * k))) in_len = 4'(k + 1);
    end
  end

  assign take         = valid_q & bus.out_ready;
  // A new value may enter on the same edge the final byte leaves (no bubble).
  assign bus.in_ready = (state_q == IDLE) | (take & last_q);
  assign accept       = bus.in_valid & bus.in_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    last_d  = last_q;
    byte_d  = byte_q;
    len_d   = len_q;
    rem_d   = rem_q;
    shift_d = shift_q;

    case (state_q)
      IDLE: ;
      EMIT: begin
        if (take) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            byte_d  = 8'h00;
            state_d = IDLE;
          end else begin
            byte_d  = {rem_q > 4'd1, shift_q[6:0]};
            last_d  = (rem_q == 4'd1);
            shift_d = shift_q >> 7;
            rem_d   = rem_q - 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // accept is only possible in IDLE or while the last byte is taken,
    // so it overrides whatever the case above decided.
    if (accept) begin
      byte_d  = {in_len > 4'd1, bus.in_val[6:0]};
      last_d  = (in_len == 4'd1);
      len_d   = in_len;
      shift_d = bus.in_val[DATA_W-1:7];
      rem_d   = in_len - 4'd1;
      valid_d = 1'b1;
      state_d = EMIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      byte_q  <= 8'h00;
      len_q   <= 4'd0;
      rem_q   <= 4'd0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      byte_q  <= byte_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      shift_q <= shift_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.out_byte  = byte_q;
  assign bus.out_len   = len_q;

endmodule

// File: tb/tb_varint_encoder.sv
// tb_varint_encoder: directed, table-driven check of varint_encoder plus
// hand-written sequences for backpressure, back-to-back and mid-varint reset.
module tb_varint_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  varint_if #(.DATA_W(64)) bus ();

  varint_encoder #(.DATA_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] val;
    int          len;
    logic [79:0] bytes;   // byte i at [8*i +: 8]
  } vec_t;

  vec_t vecs [11];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // {out_valid, out_last, out_len, out_byte}
  function automatic logic [13:0] ow();
    return {bus.out_valid, bus.out_last, bus.out_len, bus.out_byte};
  endfunction

  function automatic logic [13:0] ew(input logic v, input logic l, input logic [3:0] n,
                                     input logic [7:0] b);
    return {v, l, n, b};
  endfunction

  task automatic send_vec(input vec_t v, input string nm);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_val    = v.val;
    bus.out_ready = 1'b1;
    #1 chk({nm, " in_ready"}, bus.in_ready, 1'b1);
    for (int i = 0; i < v.len; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_val   = ~v.val;   // must not disturb the varint in flight
      #1 chk($sformatf("%s byte%0d", nm, i), ow(),
             ew(1'b1, i == v.len - 1, 4'(v.len), v.bytes[8*i +: 8]));
    end
    @(negedge clk);
    #1 chk({nm, " idle_after"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{64'd0,     1, 80'h00};
    vecs[1]  = '{64'd300,   2, 80'h02AC};
    vecs[2]  = '{64'd150,   2, 80'h0196};
    vecs[3]  = '{64'd127,   1, 80'h7F};
    vecs[4]  = '{64'd128,   2, 80'h0180};
    vecs[5]  = '{64'd16383, 2, 80'h7FFF};
    vecs[6]  = '{64'd16384, 3, 80'h018080};
    vecs[7]  = '{64'h00FF_FFFF_FFFF_FFFF, 8, 80'h7F_FF_FF_FF_FF_FF_FF_FF};
    vecs[8]  = '{64'h0100_0000_0000_0000, 9, 80'h01_80_80_80_80_80_80_80_80};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 10, 80'h01_FF_FF_FF_FF_FF_FF_FF_FF_FF};
    vecs[10] = '{64'h8000_0000_0000_0000, 10, 80'h01_80_80_80_80_80_80_80_80_80};

    bus.in_valid  = 1'b0;
    bus.in_val    = '0;
    bus.out_ready = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset outputs", ow(), 14'h0);
    chk("reset in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) send_vec(vecs[v], $sformatf("vec%0d", v));

    // backpressure: 300 with out_ready low for 3 cycles
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_val    = 64'd300;
    bus.out_ready = 1'b0;
    #1 chk("bp in_ready idle", bus.in_ready, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.in_val    = 64'd0;
      bus.out_ready = (c == 3);
      #1;
      chk($sformatf("bp hold%0d", c), ow(), ew(1'b1, 1'b0, 4'd2, 8'hAC));
      chk($sformatf("bp in_ready%0d", c), bus.in_ready, 1'b0);
    end
    @(negedge clk);
    #1;
    chk("bp byte1", ow(), ew(1'b1, 1'b1, 4'd2, 8'h02));
    chk("bp in_ready last", bus.in_ready, 1'b1);
    @(negedge clk);
    #1 chk("bp idle_after", bus.out_valid, 1'b0);

    // back-to-back 1, 128, 5
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_val    = 64'd1;
    bus.out_ready = 1'b1;
    #1 chk("b2b in_ready0", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_val = 64'd128;
    #1;
    chk("b2b byte0", ow(), ew(1'b1, 1'b1, 4'd1, 8'h01));
    chk("b2b in_ready1", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_val = 64'd5;
    #1;
    chk("b2b byte1", ow(), ew(1'b1, 1'b0, 4'd2, 8'h80));
    chk("b2b in_ready2", bus.in_ready, 1'b0);
    @(negedge clk);
    #1;
    chk("b2b byte2", ow(), ew(1'b1, 1'b1, 4'd2, 8'h01));
    chk("b2b in_ready3", bus.in_ready, 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk("b2b byte3", ow(), ew(1'b1, 1'b1, 4'd1, 8'h05));
    @(negedge clk);
    #1 chk("b2b idle_after", bus.out_valid, 1'b0);

    // reset in the middle of a 10-byte varint
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_val   = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 chk($sformatf("rst pre byte%0d", i), ow(), ew(1'b1, 1'b0, 4'd10, 8'hFF));
    end
    @(negedge clk);
    rst_n        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_val   = 64'd7;
    #1;
    chk("rst outputs", ow(), 14'h0);
    chk("rst in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    #1 chk("rst no capture", ow(), 14'h0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus.in_valid = 1'b0;
    #1 chk("rst released", ow(), 14'h0);
    send_vec('{64'd1, 1, 80'h01}, "post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
